lcd_refresh_scheduler: RTL and testbench

- Sequences the binary-to-LCD converter and owns the 32-character LCD buffer write port.
- Issues periodic update requests to the converter and forwards its 32 character writes to the buffer.
- Arbitrates the buffer between the converter and a message/menu writer.
- Holds the X/Y versus R/theta display mode stable for the whole of each frame.

---
 rtl/lcd_pkg.sv | 15 +
 rtl/lcd_tick_gen.sv | 33 +++
 rtl/lcd_refresh_scheduler.sv | 159 +++++++++++++++
 tb/tb_lcd_refresh_scheduler.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD refresh scheduler.
package lcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    CONV = 2'd2,
    MSG  = 2'd3
  } lcd_state_e;

  localparam int unsigned LCD_CHARS     = 32;
  localparam logic [4:0]  LCD_LAST_ADDR = 5'd31;
  localparam logic [7:0]  ASCII_SPACE   = 8'h20;

endpackage

// File: rtl/lcd_tick_gen.sv
// Refresh tick divider: counts 0..DIV-1 while enabled and emits a tick on wrap.
// A wrap while frozen still restarts the period but produces no tick.
module lcd_tick_gen #(
  parameter int unsigned DIV = 5000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable_i,
  input  logic freeze_i,
  output logic tick_o
);

  localparam int unsigned CW = $clog2(DIV);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          wrap;

  assign wrap   = enable_i && (cnt_q == CW'(DIV - 1));
  assign tick_o = wrap && !freeze_i;

  // Next count: held at zero while disabled, restarts on wrap.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (!enable_i || wrap) cnt_d = '0;
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/lcd_refresh_scheduler.sv
// Sequences the binary-to-LCD converter and arbitrates the 32-character
// buffer write port between the converter and the message/menu writer.
//
// state | meaning
// IDLE  | waiting; message request wins over a pending refresh tick
// ARM   | conv_update held high for UPD_W cycles, timeout already running
// CONV  | converter writes forwarded; ends on addr 31 or timeout
// MSG   | buffer granted to the message writer while msg_req stays high
module lcd_refresh_scheduler
  import lcd_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 5000000,
  parameter int unsigned UPD_W        = 2,
  parameter int unsigned CONV_TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       freeze,
  input  logic       mode_req,
  output logic       conv_update,
  output logic       conv_ismagphase,
  input  logic       conv_we,
  input  logic [4:0] conv_addr,
  input  logic [7:0] conv_dat,
  input  logic       msg_req,
  output logic       msg_gnt,
  input  logic       msg_we,
  input  logic [4:0] msg_addr,
  input  logic [7:0] msg_dat,
  output logic       buf_we,
  output logic [4:0] buf_addr,
  output logic [7:0] buf_dat,
  output logic       busy,
  output logic       frame_done,
  output logic       timeout_err
);

  localparam int unsigned UW = $clog2(UPD_W + 1);
  localparam int unsigned TW = $clog2(CONV_TIMEOUT + 1);

  lcd_state_e    state_q, state_d;
  logic          tick;
  logic          tick_pend_q, tick_pend_d;
  logic          mag_q, mag_d;
  logic [UW-1:0] upd_cnt_q, upd_cnt_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          err_q, err_d;
  logic          bwe_q, bwe_d;
  logic [4:0]    baddr_q, baddr_d;
  logic [7:0]    bdat_q, bdat_d;
  logic          fdone_q, fdone_d;

  lcd_tick_gen #(.DIV(REFRESH_DIV)) u_tick (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable_i (enable),
    .freeze_i (freeze),
    .tick_o   (tick)
  );

  assign conv_update     = (state_q == ARM);
  assign conv_ismagphase = mag_q;
  assign msg_gnt         = (state_q == MSG) && msg_req;
  assign busy            = (state_q != IDLE);
  assign buf_we          = bwe_q;
  assign buf_addr        = baddr_q;
  assign buf_dat         = bdat_q;
  assign frame_done      = fdone_q;
  assign timeout_err     = err_q;

  // Next-state, write mux and timeout down-counter; the counter is loaded on
  // IDLE->ARM so the budget covers the update pulse as well as the writes.
  always_comb begin
    state_d     = state_q;
    tick_pend_d = tick_pend_q | tick;
    mag_d       = mag_q;
    upd_cnt_d   = upd_cnt_q;
    to_cnt_d    = to_cnt_q;
    err_d       = err_q;
    bwe_d       = 1'b0;
    baddr_d     = baddr_q;
    bdat_d      = bdat_q;
    fdone_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (msg_req) begin
          state_d = MSG;
        end else if (tick_pend_q) begin
          state_d     = ARM;
          tick_pend_d = tick;
          mag_d       = mode_req;
          upd_cnt_d   = UW'(UPD_W - 1);
          to_cnt_d    = TW'(CONV_TIMEOUT - 1);
        end
      end
      ARM: begin
        if (to_cnt_q != '0) to_cnt_d = to_cnt_q - 1'b1;
        if (upd_cnt_q == '0) state_d = CONV;
        else                 upd_cnt_d = upd_cnt_q - 1'b1;
      end
      CONV: begin
        if (conv_we) begin
          bwe_d   = 1'b1;
          baddr_d = conv_addr;
          bdat_d  = conv_dat;
        end
        if (conv_we && (conv_addr == LCD_LAST_ADDR)) begin
          fdone_d = 1'b1;
          state_d = IDLE;
          if (enable) err_d = 1'b0;
        end else if (to_cnt_q == '0) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          to_cnt_d = to_cnt_q - 1'b1;
        end
      end
      MSG: begin
        if (!msg_req) begin
          state_d = IDLE;
        end else if (msg_we) begin
          bwe_d   = 1'b1;
          baddr_d = msg_addr;
          bdat_d  = msg_dat;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tick_pend_q <= 1'b0;
      mag_q       <= 1'b0;
      upd_cnt_q   <= '0;
      to_cnt_q    <= '0;
      err_q       <= 1'b0;
      bwe_q       <= 1'b0;
      baddr_q     <= '0;
      bdat_q      <= '0;
      fdone_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_pend_q <= tick_pend_d;
      mag_q       <= mag_d;
      upd_cnt_q   <= upd_cnt_d;
      to_cnt_q    <= to_cnt_d;
      err_q       <= err_d;
      bwe_q       <= bwe_d;
      baddr_q     <= baddr_d;
      bdat_q      <= bdat_d;
      fdone_q     <= fdone_d;
    end
  end

endmodule

// File: tb/tb_lcd_refresh_scheduler.sv
// Bench for lcd_refresh_scheduler: plays converter and message writer with
// random data/gaps; a write scoreboard and a 32-character buffer image give
// the expected buffer traffic, frame timing is computed from the tick period.
module tb_lcd_refresh_scheduler;
  import lcd_pkg::*;

  localparam int unsigned DIV  = 100;
  localparam int unsigned UPDW = 2;
  localparam int unsigned TMO  = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       enable = 1'b0, freeze = 1'b0, mode_req = 1'b0;
  logic       conv_we = 1'b0, msg_req = 1'b0, msg_we = 1'b0;
  logic [4:0] conv_addr = '0, msg_addr = '0;
  logic [7:0] conv_dat = '0, msg_dat = '0;
  logic       conv_update, conv_ismagphase, msg_gnt, buf_we, busy, frame_done, timeout_err;
  logic [4:0] buf_addr;
  logic [7:0] buf_dat;

  lcd_refresh_scheduler #(.REFRESH_DIV(DIV), .UPD_W(UPDW), .CONV_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .freeze(freeze), .mode_req(mode_req),
    .conv_update(conv_update), .conv_ismagphase(conv_ismagphase),
    .conv_we(conv_we), .conv_addr(conv_addr), .conv_dat(conv_dat),
    .msg_req(msg_req), .msg_gnt(msg_gnt), .msg_we(msg_we), .msg_addr(msg_addr), .msg_dat(msg_dat),
    .buf_we(buf_we), .buf_addr(buf_addr), .buf_dat(buf_dat),
    .busy(busy), .frame_done(frame_done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;

  task automatic chk_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [4:0] a;
    logic [7:0] d;
    logic       last;
  } wr_t;

  wr_t        exp_q[$];
  wr_t        mon_e;
  logic [7:0] exp_buf [LCD_CHARS];
  logic [7:0] obs_buf [LCD_CHARS];
  int         fd_cnt = 0;

  task automatic push_wr(input logic [4:0] a, input logic [7:0] d, input logic last);
    wr_t e;
    e.a = a; e.d = d; e.last = last;
    exp_q.push_back(e);
    exp_buf[a] = d;
  endtask

  // Monitor: every buffer write must match the next accepted write, in order.
  always @(negedge clk) begin
    if (frame_done === 1'b1) fd_cnt++;
    if (buf_we === 1'b1) begin
      obs_buf[buf_addr] = buf_dat;
      if (exp_q.size() == 0) begin
        chk_val("buf_we_unexpected", buf_we, 1'b0);
      end else begin
        mon_e = exp_q.pop_front();
        chk_val("buf_addr", buf_addr, mon_e.a);
        chk_val("buf_dat", buf_dat, mon_e.d);
        chk_val("frame_done_align", frame_done, mon_e.last);
      end
    end else if (frame_done !== 1'b0) begin
      chk_val("frame_done_stray", frame_done, 1'b0);
    end
  end

  // Converter model: wait for the update pulse, then write addresses 0..nwr-1
  // with random data and random idle gaps; optional mode toggle and reset pulse.
  task automatic conv_run(input int nwr, input int tog_at, input int rst_at,
                          output int rc, output logic mag_rise);
    int n = 0, w = 0, gap = 20;
    bit aborted = 0;
    logic [7:0] d;
    rc = -1; mag_rise = 1'bx;
    while (conv_update !== 1'b1 && n < 3 * DIV) begin @(negedge clk); n++; end
    if (conv_update !== 1'b1) begin
      chk_val("upd_wait", conv_update, 1'b1);
      return;
    end
    rc = cyc;
    mag_rise = conv_ismagphase;
    while (conv_update === 1'b1 && w < 8) begin w++; @(negedge clk); end
    chk_val("upd_width", w, UPDW);
    for (int a = 0; a < nwr; a++) begin
      while (gap > 0 && $urandom_range(0, 3) == 0) begin gap--; @(negedge clk); end
      d = 8'($urandom);
      conv_we = 1'b1; conv_addr = 5'(a); conv_dat = d;
      if (!aborted) push_wr(5'(a), d, a == 31);
      if (a == tog_at) mode_req = 1'b1;
      @(negedge clk);
      conv_we = 1'b0;
      if (aborted) chk_val("rst_drop", buf_we, 1'b0);
      if (a == rst_at) begin
        #2 rst_n = 1'b0;
        #1;
        chk_val("rst_mid_outs", {conv_update, conv_ismagphase, msg_gnt, buf_we, busy,
                                 frame_done, timeout_err, buf_addr, buf_dat}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        aborted = 1;
      end
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got still running, want finished");
    $fatal(1);
  end

  initial begin
    int E, rc, d0, fd0;
    logic mr;
    for (int i = 0; i < LCD_CHARS; i++) begin
      exp_buf[i] = ASCII_SPACE;
      obs_buf[i] = ASCII_SPACE;
    end
    #1 rst_n = 1'b0;
    #2;
    chk_val("rst_ctrl", {conv_update, conv_ismagphase, msg_gnt, buf_we, busy, frame_done, timeout_err}, 0);
    chk_val("rst_bus", {buf_addr, buf_dat}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk_val("idle_busy", busy, 0);

    // Disabled: no refresh at all.
    repeat (150) begin
      @(negedge clk);
      chk_val("noen_upd", conv_update, 0);
    end

    // Counter leaves 0 on the first enabled edge, ticks at DIV-1, one cycle to
    // register the pending tick, one more for IDLE->ARM: update at E+DIV+1.
    E = cyc;
    enable = 1'b1;
    conv_run(32, $urandom_range(5, 25), -1, rc, mr);
    chk_val("f1_start", rc, E + DIV + 1);
    chk_val("f1_mag", mr, 0);
    @(negedge clk);
    chk_val("f1_busy", busy, 0);
    chk_val("f1_fd", fd_cnt, 1);
    chk_val("f1_mag_hold", conv_ismagphase, 0);

    conv_run(32, -1, -1, rc, mr);
    chk_val("f2_start", rc, E + 2 * DIV + 1);
    chk_val("f2_mag", mr, 1);
    @(negedge clk);
    chk_val("f2_fd", fd_cnt, 2);

    // Message request in the same cycle as the third tick.
    while (cyc < E + 3 * DIV - 1) @(negedge clk);
    msg_req = 1'b1;
    @(negedge clk);
    chk_val("msg_gnt", msg_gnt, 1);
    chk_val("msg_no_upd", conv_update, 0);
    for (int i = 0; i < 5; i++) begin
      msg_we = 1'b1; msg_addr = 5'(16 + i); msg_dat = 8'($urandom);
      push_wr(msg_addr, msg_dat, 1'b0);
      if (i == 2) begin conv_we = 1'b1; conv_addr = LCD_LAST_ADDR; conv_dat = 8'h3c; end
      @(negedge clk);
      msg_we = 1'b0; conv_we = 1'b0;
    end
    msg_req = 1'b0; msg_we = 1'b1; msg_addr = 5'd3; msg_dat = 8'haa;
    #1 chk_val("msg_gnt_drop", msg_gnt, 0);
    d0 = cyc;
    @(negedge clk);
    msg_we = 1'b0;

    // The kept tick is served right after MSG; this frame never writes addr 31.
    conv_run(20, -1, -1, rc, mr);
    chk_val("msg_then_arm", rc, d0 + 2);
    fd0 = fd_cnt;
    while (cyc < rc + TMO - 1) @(negedge clk);
    chk_val("tmo_pre_err", timeout_err, 0);
    chk_val("tmo_pre_busy", busy, 1);
    @(negedge clk);
    chk_val("tmo_err", timeout_err, 1);
    chk_val("tmo_idle", busy, 0);
    conv_we = 1'b1; conv_addr = LCD_LAST_ADDR; conv_dat = 8'h55;
    @(negedge clk);
    conv_we = 1'b0;
    @(negedge clk);
    chk_val("tmo_no_fd", fd_cnt, fd0);

    conv_run(32, -1, -1, rc, mr);
    chk_val("f4_start", rc, E + 4 * DIV + 1);
    @(negedge clk);
    chk_val("f4_clr_err", timeout_err, 0);
    chk_val("f4_fd", fd_cnt, fd0 + 1);

    // Freeze across several tick periods with stray converter writes.
    while (cyc < E + 4 * DIV + 70) @(negedge clk);
    freeze = 1'b1;
    while (cyc < E + 8 * DIV + 50) begin
      if ($urandom_range(0, 7) == 0) begin
        conv_we = 1'b1; conv_addr = 5'($urandom); conv_dat = 8'($urandom);
      end
      @(negedge clk);
      conv_we = 1'b0;
      chk_val("frz_upd", conv_update, 0);
    end
    freeze = 1'b0;

    // First tick after freeze; reset lands after write 10.
    conv_run(32, -1, 10, rc, mr);
    chk_val("f5_start", rc, E + 9 * DIV + 1);
    @(negedge clk);
    chk_val("f5_idle", busy, 0);
    chk_val("f5_no_fd", fd_cnt, fd0 + 1);
    chk_val("sb_left", exp_q.size(), 0);
    for (int i = 0; i < LCD_CHARS; i++)
      chk_val($sformatf("buf_img_%0d", i), obs_buf[i], exp_buf[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
